// File: rtl/ipv4_parser_if.sv
// Byte-stream bundle between the Ethernet MAC parser and the IPv4 parser.
// master drives the Ethernet side; slave (the parser) drives the IP side.
interface ipv4_parser_if;
  typedef logic [7:0] byte_t;

  byte_t eth_data_in;
  logic  eth_byte_valid;
  logic  eth_eof;
  logic  eth_err;
  byte_t ip_data_out;
  logic  ip_byte_valid;
  logic  ip_eof;
  logic  ip_err;

  modport master (
    output eth_data_in, eth_byte_valid, eth_eof, eth_err,
    input  ip_data_out, ip_byte_valid, ip_eof, ip_err
  );

  modport slave (
    input  eth_data_in, eth_byte_valid, eth_eof, eth_err,
    output ip_data_out, ip_byte_valid, ip_eof, ip_err
  );
endinterface

// File: rtl/ipv4_parser.sv
// Receive-side IPv4 header parser: checks version/IHL/length/protocol/destination,
// forwards only IP payload bytes and flags rejected or corrupted datagrams at end of frame.
module ipv4_parser #(
  parameter logic [7:0]  TRANSPORT_PROTOCOL = 8'd17,
  parameter logic [31:0] IP_ADDRESS         = 32'hC0A80101
) (
  input  logic          clk,
  input  logic          rst_n,
  ipv4_parser_if.slave  bus
);
  typedef logic [7:0] byte_t;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned HL_W  = 6;
  localparam int unsigned DST_W = 24;

  typedef enum logic [1:0] {HEADER, PAYLOAD, DROP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  total_len_q, total_len_d;
  logic [HL_W-1:0]   hdr_len_q, hdr_len_d;
  logic [DST_W-1:0]  dst_q, dst_d;
  logic              err_q, err_d;
  byte_t             data_q, data_d;
  logic              valid_q, valid_d;
  logic              eof_q, eof_d;
  logic              perr_q, perr_d;

  byte_t             b_c;
  logic              hdr_err_c;
  logic              hdr_done_c;
  logic              short_c;

  // Next-state and next-output logic; all work happens on a valid input strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    total_len_d = total_len_q;
    hdr_len_d   = hdr_len_q;
    dst_d       = dst_q;
    err_d       = err_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    eof_d       = 1'b0;
    perr_d      = 1'b0;
    hdr_err_c   = 1'b0;
    hdr_done_c  = 1'b0;
    short_c     = 1'b0;
    b_c         = bus.eth_data_in;

    if (bus.eth_byte_valid) begin
      // Saturate so long padding runs can never wrap back into the payload window
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);

      unique case (state_q)
        HEADER: begin
          case (cnt_q)
            16'd0: begin
              hdr_len_d = {b_c[3:0], 2'b00};
              if (b_c[7:4] != 4'd4 || b_c[3:0] < 4'd5) hdr_err_c = 1'b1;
            end
            16'd2: total_len_d = {b_c, 8'h00};
            16'd3: begin
              total_len_d = {total_len_q[15:8], b_c};
              if (total_len_d < CNT_W'(hdr_len_q)) hdr_err_c = 1'b1;
            end
            16'd9: if (b_c != TRANSPORT_PROTOCOL) hdr_err_c = 1'b1;
            16'd16, 16'd17, 16'd18: dst_d = {dst_q[15:0], b_c};
            16'd19: if ({dst_q, b_c} != IP_ADDRESS) hdr_err_c = 1'b1;
            default: ;
          endcase
          hdr_done_c = (cnt_q >= 16'd19) && (cnt_q == CNT_W'(hdr_len_q) - CNT_W'(1));
          if (hdr_err_c)       state_d = DROP;
          else if (hdr_done_c) state_d = PAYLOAD;
        end
        PAYLOAD: begin
          if (cnt_q < total_len_q) begin
            valid_d = 1'b1;
            data_d  = b_c;
          end
        end
        DROP: ;
        default: state_d = DROP;
      endcase

      if (hdr_err_c) err_d = 1'b1;

      if (bus.eth_eof) begin
        short_c = ({1'b0, cnt_q} + 17'd1) < {1'b0, total_len_q};
        eof_d   = 1'b1;
        perr_d  = err_q | hdr_err_c | bus.eth_err | short_c |
                  ((state_q == HEADER) && !hdr_done_c);
        state_d = HEADER;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HEADER;
      cnt_q       <= '0;
      total_len_q <= '0;
      hdr_len_q   <= '0;
      dst_q       <= '0;
      err_q       <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      eof_q       <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      total_len_q <= total_len_d;
      hdr_len_q   <= hdr_len_d;
      dst_q       <= dst_d;
      err_q       <= err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      eof_q       <= eof_d;
      perr_q      <= perr_d;
    end
  end

  assign bus.ip_data_out   = data_q;
  assign bus.ip_byte_valid = valid_q;
  assign bus.ip_eof        = eof_q;
  assign bus.ip_err        = perr_q;
endmodule

// File: tb/tb_ipv4_parser.sv
// Self-checking bench for ipv4_parser: directed and randomized frames compared
// against a frame-level reference model of which bytes are forwarded and when ip_err fires.
module tb_ipv4_parser;
  localparam logic [31:0] MY_IP = 32'hC0A80101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ipv4_parser_if bus();
  ipv4_parser dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fr[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         exp_err;
  bit         eof_errs[$];
  bit         eof_with_byte;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.ip_byte_valid) got_q.push_back(bus.ip_data_out);
    if (bus.ip_eof) begin
      eof_errs.push_back(bus.ip_err);
      eof_with_byte = bus.ip_byte_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    got_q.delete();
    eof_errs.delete();
    eof_with_byte = 1'b0;
  endtask

  task automatic settle();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input int tot,
                       input logic [7:0] proto, input logic [31:0] dst,
                       input int plen, input int pad);
    fr.delete();
    fr.push_back({ver, ihl});
    fr.push_back(8'h00);
    fr.push_back(8'(tot >> 8));
    fr.push_back(8'(tot));
    for (int i = 4; i <= 8; i++) fr.push_back(8'($urandom));
    fr.push_back(proto);
    for (int i = 10; i <= 15; i++) fr.push_back(8'($urandom));
    fr.push_back(dst[31:24]);
    fr.push_back(dst[23:16]);
    fr.push_back(dst[15:8]);
    fr.push_back(dst[7:0]);
    for (int i = 20; i < int'(ihl) * 4; i++) fr.push_back(8'($urandom));
    for (int i = 0; i < plen; i++) fr.push_back(8'($urandom));
    for (int i = 0; i < pad; i++) fr.push_back(8'($urandom));
  endtask

  // Reference model: which bytes of fr reach the output, and whether the datagram is rejected.
  task automatic run_model(input bit crc);
    int n, hl, tot;
    bit herr;
    n = fr.size();
    exp_q.delete();
    herr = 1'b0;
    tot = 0;
    hl = int'(fr[0][3:0]) * 4;
    if (fr[0][7:4] != 4'd4 || fr[0][3:0] < 4'd5) herr = 1'b1;
    if (n >= 4) begin
      tot = int'(fr[2]) * 256 + int'(fr[3]);
      if (tot < hl) herr = 1'b1;
    end
    if (n >= 10 && fr[9] != 8'd17) herr = 1'b1;
    if (n >= 20 && {fr[16], fr[17], fr[18], fr[19]} != MY_IP) herr = 1'b1;
    exp_err = herr || (n < hl) || (n < tot) || crc;
    if (!herr)
      for (int i = hl; i < n && i < tot; i++) exp_q.push_back(fr[i]);
  endtask

  // Drive the first nbytes of fr; eof only goes out with the true last byte.
  task automatic send(input bit crc, input int gap, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      bus.eth_byte_valid = 1'b1;
      bus.eth_data_in    = fr[i];
      bus.eth_eof        = (i == fr.size() - 1);
      bus.eth_err        = crc && (i == fr.size() - 1);
      @(posedge clk); #1;
      bus.eth_byte_valid = 1'b0;
      bus.eth_eof        = 1'b0;
      bus.eth_err        = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (bus.ip_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.ip_data_out); end
    n_checks++; if (bus.ip_byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.ip_byte_valid); end
    n_checks++; if (bus.ip_eof !== 1'b0) begin n_fail++; $display("FAIL reset_eof: got %b want 0", bus.ip_eof); end
    n_checks++; if (bus.ip_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.ip_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_valid_frame(input bit crc);
    clear_mon();
    build(4'd4, 4'd5, 75, 8'd17, MY_IP, 55, 0);
    run_model(crc);
    send(crc, 3, fr.size());
    settle();
    n_checks++; if (got_q.size() !== 55) begin n_fail++; $display("FAIL valid_count crc=%0d: got %0d want 55", crc, got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL valid_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (eof_errs.size() != 1 || eof_errs[0] !== crc) begin
      n_fail++; $display("FAIL valid_eof crc=%0d: eofs %0d want 1, err want %0d", crc, eof_errs.size(), crc);
    end
    n_checks++; if (eof_with_byte !== 1'b1) begin n_fail++; $display("FAIL valid_eof_with_last: got %b want 1", eof_with_byte); end
  endtask

  task automatic test_bad_header();
    for (int v = 0; v < 3; v++) begin
      clear_mon();
      case (v)
        0: build(4'd3, 4'd5, 75, 8'd17, MY_IP, 55, 0);
        1: build(4'd4, 4'd5, 75, 8'd17, 32'hC0A80102, 55, 0);
        default: build(4'd4, 4'd5, 75, 8'd6, MY_IP, 55, 0);
      endcase
      send(1'b0, 1, fr.size());
      settle();
      n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL bad_hdr%0d_count: got %0d want 0", v, got_q.size()); end
      n_checks++;
      if (eof_errs.size() != 1 || eof_errs[0] !== 1'b1) begin
        n_fail++; $display("FAIL bad_hdr%0d_eof: eofs %0d want 1 with err 1", v, eof_errs.size());
      end
    end
  endtask

  task automatic test_padding();
    clear_mon();
    build(4'd4, 4'd5, 40, 8'd17, MY_IP, 20, 6);
    run_model(1'b0);
    send(1'b0, 0, fr.size());
    settle();
    n_checks++; if (got_q.size() !== 20) begin n_fail++; $display("FAIL pad_count: got %0d want 20", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pad_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (eof_errs.size() != 1 || eof_errs[0] !== 1'b0) begin
      n_fail++; $display("FAIL pad_eof: eofs %0d want 1 with err 0", eof_errs.size());
    end
    n_checks++; if (eof_with_byte !== 1'b0) begin n_fail++; $display("FAIL pad_eof_alone: got %b want 0", eof_with_byte); end
  endtask

  task automatic test_one_byte();
    clear_mon();
    fr.delete();
    fr.push_back(8'h45);
    send(1'b0, 0, 1);
    settle();
    n_checks++;
    if (eof_errs.size() != 1 || eof_errs[0] !== 1'b1 || got_q.size() != 0) begin
      n_fail++; $display("FAIL one_byte: eofs %0d bytes %0d want 1 eof with err, 0 bytes", eof_errs.size(), got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    build(4'd4, 4'd5, 30, 8'd6, MY_IP, 10, 0);
    send(1'b0, 0, fr.size());
    build(4'd4, 4'd6, 36, 8'd17, MY_IP, 12, 0);
    run_model(1'b0);
    send(1'b0, 0, fr.size());
    settle();
    n_checks++;
    if (eof_errs.size() != 2) begin n_fail++; $display("FAIL b2b_eofs: got %0d want 2", eof_errs.size()); end
    else begin
      n_checks++; if (eof_errs[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_err0: got %b want 1", eof_errs[0]); end
      n_checks++; if (eof_errs[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_err1: got %b want 0", eof_errs[1]); end
    end
    n_checks++;
    if (got_q != exp_q) begin n_fail++; $display("FAIL b2b_payload: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    build(4'd4, 4'd5, 60, 8'd17, MY_IP, 40, 0);
    fr[25] = 8'hA5;
    send(1'b0, 0, 26);
    n_checks++; if (bus.ip_byte_valid !== 1'b1 || bus.ip_data_out !== 8'hA5) begin
      n_fail++; $display("FAIL mid_pre: valid %b data %h want 1 a5", bus.ip_byte_valid, bus.ip_data_out);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.ip_byte_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", bus.ip_byte_valid); end
    n_checks++; if (bus.ip_data_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data: got %h want 00", bus.ip_data_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Abandon a second frame mid-header.
    build(4'd4, 4'd5, 30, 8'd17, MY_IP, 10, 0);
    send(1'b0, 0, 8);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (eof_errs.size() !== 0) begin n_fail++; $display("FAIL mid_no_eof: got %0d eofs want 0", eof_errs.size()); end
    clear_mon();
    build(4'd4, 4'd5, 45, 8'd17, MY_IP, 25, 2);
    run_model(1'b0);
    send(1'b0, 1, fr.size());
    settle();
    n_checks++;
    if (got_q != exp_q) begin n_fail++; $display("FAIL mid_after_payload: got %0d bytes want %0d", got_q.size(), exp_q.size()); end
    n_checks++;
    if (eof_errs.size() != 1 || eof_errs[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_after_eof: eofs %0d want 1 with err 0", eof_errs.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [3:0]  ver, ihl;
      logic [7:0]  proto;
      logic [31:0] dst;
      int hl, plen, pad, mode, tot, k;
      bit crc;
      clear_mon();
      ihl   = 4'($urandom_range(5, 7));
      hl    = int'(ihl) * 4;
      plen  = $urandom_range(0, 30);
      pad   = $urandom_range(0, 4);
      mode  = $urandom_range(0, 6);
      ver   = 4'd4;
      proto = 8'd17;
      dst   = MY_IP;
      tot   = hl + plen;
      crc   = 1'b0;
      case (mode)
        1: begin ver = 4'($urandom_range(0, 15)); if (ver == 4'd4) ver = 4'd6; end
        2: proto = 8'($urandom_range(0, 16));
        3: dst = MY_IP ^ (32'h1 << $urandom_range(0, 31));
        5: crc = 1'b1;
        6: tot = $urandom_range(0, hl - 1);
        default: ;
      endcase
      build(ver, ihl, tot, proto, dst, plen, pad);
      if (mode == 4) begin
        k = $urandom_range(1, fr.size() - 1);
        repeat (k) void'(fr.pop_back());
      end
      run_model(crc);
      send(crc, $urandom_range(0, 2), fr.size());
      settle();
      n_checks++;
      if (got_q != exp_q) begin
        n_fail++; $display("FAIL rand%0d_payload mode=%0d: got %0d bytes want %0d", it, mode, got_q.size(), exp_q.size());
      end
      n_checks++;
      if (eof_errs.size() != 1 || eof_errs[0] !== exp_err) begin
        n_fail++; $display("FAIL rand%0d_eof mode=%0d: eofs %0d want 1, err want %0d", it, mode, eof_errs.size(), exp_err);
      end
    end
  endtask

  initial begin
    bus.eth_data_in    = 8'h00;
    bus.eth_byte_valid = 1'b0;
    bus.eth_eof        = 1'b0;
    bus.eth_err        = 1'b0;
    clear_mon();
    test_reset();
    test_valid_frame(1'b0);
    test_bad_header();
    test_valid_frame(1'b1);
    test_padding();
    test_one_byte();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ipv4_parser.md
# ipv4_parser

Receive-side IPv4 header parser between the Ethernet MAC parser (byte stream with end-of-frame and CRC error flags) and the transport-layer parser. It consumes one Ethernet payload byte per valid strobe. It validates the IPv4 header against a fixed local address and transport protocol, then forwards only the IP payload bytes. It flags rejected or corrupted datagrams at end of frame.

## Interface
- TRANSPORT_PROTOCOL, 8'd17: accepted IPv4 Protocol field value (17 = UDP).
- IP_ADDRESS, 32'hC0A80101: local IPv4 address; Destination Address must match it.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- eth_data_in  in  8  incoming byte (byte_t), MSB-first network order.
- eth_byte_valid  in  1  eth_data_in valid this cycle; arbitrary gaps allowed between strobes.
- eth_eof  in  1  qualifies the current valid byte as the last byte of the frame.
- eth_err  in  1  with eth_eof: frame failed the Ethernet CRC check.
- ip_data_out  out  8  payload byte (byte_t).
- ip_byte_valid  out  1  ip_data_out valid, single-cycle pulse per byte.
- ip_eof  out  1  single-cycle pulse: datagram ended.
- ip_err  out  1  single-cycle pulse with ip_eof: datagram must be discarded.

## Operation
- States: HEADER, PAYLOAD, DROP. Reset state is HEADER with byte counter 0.
- eth_eof and eth_err are sampled only when eth_byte_valid=1.
- 16-bit byte counter counts valid input bytes from the first byte of the frame.
- HEADER byte 0: version = bits[7:4] and IHL = bits[3:0].
  - Error if version != 4 or IHL < 5.
  - Header length = IHL*4 bytes.
- Bytes 2-3: Total Length, big-endian, latched.
  - Error if Total Length < IHL*4.
- Byte 9: Protocol; error if != TRANSPORT_PROTOCOL.
- Bytes 12-15: Source Address, ignored.
- Bytes 16-19: Destination Address, assembled MSB first.
  - Error if != IP_ADDRESS (compared after byte 19).
- Bytes 1, 4-8 and 10-11 (DSCP/ECN, ID, flags/fragment, TTL, checksum) are ignored. Header checksum is NOT verified.
- Option bytes (20 .. IHL*4-1) are consumed and discarded.
- Any header error latches a sticky error flag and moves the FSM to DROP. DROP forwards nothing until eth_eof.
- PAYLOAD: bytes at index IHL*4 .. Total Length-1 are forwarded on ip_data_out/ip_byte_valid.
- Bytes beyond Total Length (Ethernet padding) are consumed but not forwarded.
- End of frame (valid byte with eth_eof=1), in any state:
  - ip_eof pulses.
  - ip_err pulses in the same cycle if any of these hold: sticky error set; eth_err=1; frame ended in HEADER; fewer than Total Length bytes received.
  - Counter and sticky error clear; FSM returns to HEADER.
- Payload already forwarded before a late error (CRC, truncation) is not retracted. Downstream discards on ip_err.
- No backpressure; the block accepts every valid byte.

## Timing
- All outputs registered. Reset values: ip_data_out=8'h00, ip_byte_valid=0, ip_eof=0, ip_err=0.
- Latency is 1 cycle: input byte at edge N appears on ip_data_out/ip_byte_valid after edge N+1.
- ip_eof/ip_err assert on the cycle after the eth_eof byte is accepted. This is the same cycle as the last payload ip_byte_valid when that byte is forwarded.
- Every output pulse lasts exactly one cycle.
- A new frame may start on the cycle immediately after an eth_eof byte.
- Reset mid-frame: all outputs clear immediately. The partial frame is abandoned, with no ip_eof. The next valid byte is header byte 0.
- eth_eof on header byte 0 (1-byte frame): ip_eof=1, ip_err=1.

## Test plan
- Valid frame: version 4, IHL 5, protocol 17, dest C0A80101, 55 random payload bytes, Total Length 75, one strobe every 4 cycles.
  - Required: exactly 55 ip_byte_valid pulses matching the payload in order; ip_eof with the last byte; ip_err=0.
- Same frame with version 3 -> no payload output; ip_eof=1 with ip_err=1.
- Dest address C0A80102 or protocol 6 -> no payload output; ip_eof=1 with ip_err=1.
- Valid frame with eth_err=1 on the final byte -> all 55 bytes forwarded; ip_eof=1 with ip_err=1.
- Frame with 20-byte payload and Total Length 40, plus 6 padding bytes -> 20 bytes forwarded; ip_eof on the padding eof; ip_err=0.
- Back-to-back frames (invalid then valid), plus rst_n pulsed mid-header:
  - Each frame gets an independent ip_eof.
  - ip_err only on the invalid frame.
  - Reset drops all outputs to 0 asynchronously.
